lifo_stack_ctrl: RTL and testbench

- Parametrised LIFO stack that replaces the fixed 8x6 backtracking stack in the 8-queen solver datapath.
- Adds the following over a plain push/pop stack:
  - occupancy count, full and empty flags;
  - combinational top-of-stack view;
  - registered pop output with a valid pulse;
  - same-cycle push+pop replace;
  - synchronous clear;
  - sticky overflow and underflow error flags.
- The solver FSM drives it: it pushes a column per placed queen, pops on backtrack, and replaces the top to advance a column in one cycle.

---
 rtl/lifo_stack_ctrl.sv | 76 +++++++
 tb/tb_lifo_stack_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/lifo_stack_ctrl.sv
// Parametrised LIFO stack for the 8-queen solver backtracking path.
// Optional LIFO_PEEK_EN adds a random-access peek port for conflict checks.
module lifo_stack_ctrl #(
  parameter  int WIDTH = 6,
  parameter  int DEPTH = 8,
  localparam int CW    = $clog2(DEPTH+1),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] in_data,
`ifdef LIFO_PEEK_EN
  input  logic [AW-1:0]    peek_idx,
  output logic [WIDTH-1:0] peek_data,
  output logic             peek_valid,
`endif
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    top_idx, wr_idx;
  logic             do_push, do_pop, do_repl, mem_we;
  logic [AW-1:0]    mem_wa;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign top_idx = AW'(count - CW'(1));
  assign wr_idx  = AW'(count);

  // 11 on an empty stack degrades to a plain push (DEPTH>=2, so never full)
  assign do_push = push && !full && (!pop || empty);
  assign do_pop  = pop && !push && !empty;
  assign do_repl = push && pop && !empty;

  assign mem_we  = !reset && !clear && (do_push || do_repl);
  assign mem_wa  = do_repl ? top_idx : wr_idx;

  assign top_data = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      out_valid <= do_pop || do_repl;
      if (do_pop || do_repl) out_data <= mem[top_idx];
      if (do_push)           count    <= count + CW'(1);
      else if (do_pop)       count    <= count - CW'(1);
      if (push && !pop && full) overflow  <= 1'b1;
      if (pop && empty)         underflow <= 1'b1;
    end
  end

`ifdef LIFO_PEEK_EN
  assign peek_valid = (CW'(peek_idx) < count);
  assign peek_data  = peek_valid ? mem[peek_idx] : '0;
`endif

endmodule

// File: tb/tb_lifo_stack_ctrl.sv
// Scoreboard bench for lifo_stack_ctrl (WIDTH=6, DEPTH=8); pops are checked by a monitor.
module tb_lifo_stack_ctrl;
  localparam int WIDTH = 6;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset, push, pop, clear;
  logic [WIDTH-1:0] in_data;
  logic [WIDTH-1:0] out_data, top_data;
  logic             out_valid, full, empty, overflow, underflow;
  logic [CW-1:0]    count;
`ifdef LIFO_PEEK_EN
  logic [AW-1:0]    peek_idx;
  logic [WIDTH-1:0] peek_data;
  logic             peek_valid;
`endif

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  lifo_stack_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .clear(clear),
    .in_data(in_data),
`ifdef LIFO_PEEK_EN
    .peek_idx(peek_idx), .peek_data(peek_data), .peek_valid(peek_valid),
`endif
    .out_data(out_data), .out_valid(out_valid), .top_data(top_data),
    .count(count), .full(full), .empty(empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_pop: got %0d expected no output", out_data);
      end else begin
        chk("pop_data", int'(out_data), exp_q.pop_front());
      end
    end
  end

  // One cycle: drive on negedge, return 1 time unit after the rising edge.
  task automatic op(input logic r, input logic c, input logic p, input logic q, input int d);
    @(negedge clk);
    reset = r; clear = c; push = p; pop = q; in_data = WIDTH'(d);
    @(posedge clk); #1;
    reset = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
  endtask

  task automatic chk_flushed(input string tag);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_ovf"},   int'(overflow), 0);
    chk({tag, "_unf"},   int'(underflow), 0);
    chk({tag, "_odata"}, int'(out_data), 0);
    chk({tag, "_top"},   int'(top_data), 0);
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; in_data = '0;
`ifdef LIFO_PEEK_EN
    peek_idx = '0;
`endif
    op(1, 0, 0, 0, 0);
    op(1, 0, 0, 0, 0);
    chk_flushed("reset");
    chk("reset_full", int'(full), 0);
    chk("reset_oval", int'(out_valid), 0);

    // Fill with 1..8, then overflow
    for (int i = 1; i <= DEPTH; i++) begin
      op(0, 0, 1, 0, i);
      chk("fill_count", int'(count), i);
      chk("fill_top", int'(top_data), i);
    end
    chk("fill_full", int'(full), 1);
    chk("fill_ovf", int'(overflow), 0);
    op(0, 0, 1, 0, 9);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_count", int'(count), 8);
    chk("ovf_top", int'(top_data), 8);

    // Drain back-to-back: 8,7,...,1
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back(8 - i);
      op(0, 0, 0, 1, 0);
      chk("drain_oval", int'(out_valid), 1);
      chk("drain_count", int'(count), 7 - i);
    end
    chk("drain_empty", int'(empty), 1);
    chk("drain_top", int'(top_data), 0);
    op(0, 0, 0, 1, 0);
    chk("unf_flag", int'(underflow), 1);
    chk("unf_odata", int'(out_data), 1);
    chk("unf_oval", int'(out_valid), 0);
    chk("unf_count", int'(count), 0);

    // Replace on {3,5} with 7
    op(0, 1, 0, 0, 0);
    op(0, 0, 1, 0, 3);
    op(0, 0, 1, 0, 5);
    exp_q.push_back(5);
    op(0, 0, 1, 1, 7);
    chk("repl_oval", int'(out_valid), 1);
    chk("repl_count", int'(count), 2);
    chk("repl_top", int'(top_data), 7);
    chk("repl_unf", int'(underflow), 0);
    for (int i = 0; i < 6; i++) op(0, 0, 1, 0, 10 + i);
    chk("repl_full", int'(full), 1);
    exp_q.push_back(15);
    op(0, 0, 1, 1, 20);
    chk("replfull_ovf", int'(overflow), 0);
    chk("replfull_count", int'(count), 8);
    chk("replfull_top", int'(top_data), 20);
    chk("replfull_oval", int'(out_valid), 1);

    // Push+pop on empty behaves as push, flags underflow
    op(0, 1, 0, 0, 0);
    op(0, 0, 1, 1, 4);
    chk("pe_count", int'(count), 1);
    chk("pe_top", int'(top_data), 4);
    chk("pe_unf", int'(underflow), 1);
    chk("pe_oval", int'(out_valid), 0);

    // Five entries with overflow set, then clear (and later reset) with push
    for (int k = 0; k < 2; k++) begin
      op(0, 1, 0, 0, 0);
      for (int i = 1; i <= DEPTH; i++) op(0, 0, 1, 0, 30 + i);
      op(0, 0, 1, 0, 50);
      for (int i = 0; i < 3; i++) begin
        exp_q.push_back(38 - i);
        op(0, 0, 0, 1, 0);
      end
      chk("pre_count", int'(count), 5);
      chk("pre_ovf", int'(overflow), 1);
      if (k == 0) begin
        op(0, 1, 1, 0, 9);
        chk_flushed("clear");
      end else begin
        op(1, 0, 1, 0, 9);
        chk_flushed("rstmid");
      end
      chk("flush_oval", int'(out_valid), 0);
    end

`ifdef LIFO_PEEK_EN
    op(0, 0, 1, 0, 2);
    op(0, 0, 1, 0, 6);
    op(0, 0, 1, 0, 1);
    peek_idx = AW'(1); #1;
    chk("peek1_data", int'(peek_data), 6);
    chk("peek1_vld", int'(peek_valid), 1);
    peek_idx = AW'(0); #1;
    chk("peek0_data", int'(peek_data), 2);
    peek_idx = AW'(3); #1;
    chk("peek3_data", int'(peek_data), 0);
    chk("peek3_vld", int'(peek_valid), 0);
`endif

    op(0, 0, 0, 0, 0);
    op(0, 0, 0, 0, 0);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
